// File: rtl/buf_rd_ctrl.sv
// Read-side controller for the clock-crossing word buffer.
// Pops one word at a time and holds it on data_2 for HOLD cycles.
module buf_rd_ctrl #(
    parameter int WIDTH = 16,
    parameter int HOLD  = 4,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             fifo_rd_en,
    output logic [WIDTH-1:0] data_2,
    output logic             data_2_valid,
    output logic             parity,
    output logic [CNT_W-1:0] word_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        LATCH,
        SHOW
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] hold_cnt;
    logic       can_read;
    logic       hold_done;

    assign can_read  = enable && !fifo_empty;
    assign hold_done = (hold_cnt == HOLD_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Hold counter: cleared on capture, counts cycles spent in SHOW.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= 8'd0;
        end else if (state == LATCH) begin
            hold_cnt <= 8'd0;
        end else if (state == SHOW) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end

    // Capture the popped word; data and parity persist until the next word.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_2   <= '0;
            parity   <= 1'b0;
            word_cnt <= '0;
        end else if (state == LATCH) begin
            data_2   <= fifo_rd_data;
            parity   <= ^fifo_rd_data;
            word_cnt <= word_cnt + 1'b1;
        end
    end

    // Next-state logic; the buffer is only consulted in IDLE and at SHOW end.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (can_read) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                state_nxt = LATCH;
            end
            LATCH: begin
                state_nxt = SHOW;
            end
            SHOW: begin
                if (hold_done) begin
                    state_nxt = can_read ? READ : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        fifo_rd_en   = 1'b0;
        data_2_valid = 1'b0;
        busy         = 1'b0;
        unique case (state)
            IDLE: begin
            end
            READ: begin
                fifo_rd_en = 1'b1;
                busy       = 1'b1;
            end
            LATCH: begin
                busy = 1'b1;
            end
            SHOW: begin
                data_2_valid = 1'b1;
                busy         = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_buf_rd_ctrl.sv
// Bench for buf_rd_ctrl: per-cycle vector table plus
// multi-cycle sequences against a small buffer model.
module tb_buf_rd_ctrl;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_empty;
    logic [15:0] fifo_rd_data;
    logic        fifo_rd_en;
    logic [15:0] data_2;
    logic        data_2_valid;
    logic        parity;
    logic [5:0]  word_cnt;
    logic        busy;

    buf_rd_ctrl #(.WIDTH(16), .HOLD(HOLD), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .data_2       (data_2),
        .data_2_valid (data_2_valid),
        .parity       (parity),
        .word_cnt     (word_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Buffer model: table mode drives empty/data directly,
    // model mode pops from mem on each sampled read request.
    logic        use_model = 1'b0;
    logic        tbl_emp = 1'b1;
    logic [15:0] tbl_data = 16'h0;
    logic [15:0] mem [256];
    logic [7:0]  wr_ptr = 8'd0;
    logic [7:0]  rd_ptr = 8'd0;
    logic [15:0] m_data = 16'h0;

    assign fifo_empty   = use_model ? (wr_ptr == rd_ptr) : tbl_emp;
    assign fifo_rd_data = use_model ? m_data : tbl_data;

    always @(posedge clk) begin
        if (use_model && fifo_rd_en && (wr_ptr != rd_ptr)) begin
            m_data <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 8'd1;
        end
    end

    typedef struct packed {
        logic        en;
        logic        emp;
        logic [15:0] d;
        logic        rd_en;
        logic [15:0] d2;
        logic        v;
        logic        par;
        logic [5:0]  cnt;
        logic        busy;
    } vec_t;

    vec_t tbl [16];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          rd_cyc  [$];
    logic [15:0] shown_d [$];
    logic        shown_p [$];
    int          runs    [$];
    int          gaps    [$];
    logic        busy_seen;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        if (fifo_rd_en) begin
            chk("no_underflow", int'(fifo_empty), 0);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push(input logic [15:0] v);
        mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        step();
        step();
        rst = 1'b0;
        wr_ptr = rd_ptr;
    endtask

    task automatic monitor(input int n);
        logic prev_v;
        logic had_run;
        int   run;
        int   gap;
        rd_cyc.delete();
        shown_d.delete();
        shown_p.delete();
        runs.delete();
        gaps.delete();
        busy_seen = 1'b0;
        prev_v  = data_2_valid;
        had_run = 1'b0;
        run = 0;
        gap = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (fifo_rd_en) rd_cyc.push_back(cyc);
            if (busy) busy_seen = 1'b1;
            if (data_2_valid) begin
                if (!prev_v) begin
                    shown_d.push_back(data_2);
                    shown_p.push_back(parity);
                    if (had_run) gaps.push_back(gap);
                end
                run++;
            end else begin
                if (prev_v) begin
                    runs.push_back(run);
                    run = 0;
                    had_run = 1'b1;
                    gap = 0;
                end
                gap++;
            end
            prev_v = data_2_valid;
        end
    endtask

    initial begin
        int bad;
        int got;
        bit seen;

        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 6'd0, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 6'd0, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 16'h0007, 1'b0, 16'h0007, 1'b1, 1'b1, 6'd1, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0007, 1'b1, 1'b1, 6'd1, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0007, 1'b1, 1'b1, 6'd1, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0007, 1'b1, 1'b1, 6'd1, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0007, 1'b0, 1'b1, 6'd1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0007, 1'b0, 1'b1, 6'd1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0007, 1'b0, 1'b1, 6'd1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0007, 1'b0, 1'b1, 6'd1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0007, 1'b0, 1'b1, 6'd1, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 16'h0003, 1'b0, 16'h0003, 1'b1, 1'b0, 6'd2, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0003, 1'b1, 1'b0, 6'd2, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0003, 1'b1, 1'b0, 6'd2, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0003, 1'b1, 1'b0, 6'd2, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0003, 1'b0, 1'b0, 6'd2, 1'b0};

        // Reset state.
        do_reset();
        chk("rst_state", int'({fifo_rd_en, data_2, data_2_valid,
                               parity, word_cnt, busy}), 0);

        // Single word, idle gating and enable-off completion.
        for (int i = 0; i < 16; i++) begin
            enable   = tbl[i].en;
            tbl_emp  = tbl[i].emp;
            tbl_data = tbl[i].d;
            step();
            chk($sformatf("vec%0d", i),
                int'({fifo_rd_en, data_2, data_2_valid, parity, word_cnt, busy}),
                int'({tbl[i].rd_en, tbl[i].d2, tbl[i].v, tbl[i].par,
                      tbl[i].cnt, tbl[i].busy}));
        end

        use_model = 1'b1;

        // Back-to-back words.
        do_reset();
        push(16'd1);
        push(16'd2);
        push(16'd3);
        enable = 1'b1;
        monitor(30);
        chk("b2b_rd_count", rd_cyc.size(), 3);
        if (rd_cyc.size() == 3) begin
            chk("b2b_space0", rd_cyc[1] - rd_cyc[0], HOLD + 2);
            chk("b2b_space1", rd_cyc[2] - rd_cyc[1], HOLD + 2);
        end
        chk("b2b_shown", shown_d.size(), 3);
        if (shown_d.size() == 3) begin
            chk("b2b_data", int'({shown_d[0], shown_d[1], shown_d[2]}),
                int'({16'd1, 16'd2, 16'd3}));
            chk("b2b_par", int'({shown_p[0], shown_p[1], shown_p[2]}), 3'b110);
        end
        chk("b2b_gaps", gaps.size(), 2);
        bad = 0;
        foreach (gaps[i]) if (gaps[i] != 2) bad++;
        chk("b2b_gap_len", bad, 0);
        bad = 0;
        foreach (runs[i]) if (runs[i] != HOLD) bad++;
        chk("b2b_run_len", bad, 0);
        chk("b2b_cnt", int'(word_cnt), 3);

        // Enable dropped during LATCH.
        do_reset();
        push(16'h0005);
        push(16'h000A);
        push(16'h000B);
        enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            step();
            seen = fifo_rd_en;
        end
        chk("drop_rd_seen", int'(seen), 1);
        step();
        enable = 1'b0;
        monitor(20);
        chk("drop_no_rd", rd_cyc.size(), 0);
        got = shown_d.size() > 0 ? int'(shown_d[0]) : -1;
        chk("drop_data", got, 16'h0005);
        got = runs.size() > 0 ? runs[0] : -1;
        chk("drop_hold", got, HOLD);
        chk("drop_busy", int'(busy), 0);
        chk("drop_empty", int'(fifo_empty), 0);
        chk("drop_cnt", int'(word_cnt), 1);

        // Counter wrap over 65 words.
        do_reset();
        for (int i = 0; i < 65; i++) push(16'(i + 1));
        enable = 1'b1;
        monitor(410);
        chk("wrap_rd_count", rd_cyc.size(), 65);
        chk("wrap_cnt", int'(word_cnt), 1);
        got = shown_d.size() > 0 ? int'(shown_d[shown_d.size() - 1]) : -1;
        chk("wrap_last", got, 65);
        bad = 0;
        foreach (runs[i]) if (runs[i] != HOLD) bad++;
        foreach (gaps[i]) if (gaps[i] != 2) bad++;
        chk("wrap_timing", bad, 0);
        chk("wrap_runs", runs.size(), 65);

        // Empty buffer, then a single word appears.
        do_reset();
        enable = 1'b1;
        monitor(100);
        chk("empty_no_rd", rd_cyc.size(), 0);
        chk("empty_busy", int'(busy_seen), 0);
        push(16'h0010);
        step();
        chk("empty_rd_next", int'(fifo_rd_en), 1);
        monitor(10);
        got = shown_d.size() > 0 ? int'({shown_p[0], shown_d[0]}) : -1;
        chk("empty_word", got, int'({1'b1, 16'h0010}));

        // Reset in the middle of SHOW.
        do_reset();
        push(16'hBEEF);
        enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = data_2_valid;
        end
        chk("mid_show_seen", int'(seen), 1);
        chk("mid_show_data", int'(data_2), 16'hBEEF);
        rst = 1'b1;
        step();
        chk("mid_rst_out", int'({fifo_rd_en, data_2, data_2_valid,
                                 parity, word_cnt, busy}), 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_idle", int'({busy, word_cnt, data_2}), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
